// File: rtl/crypto_test_mem_bist_master_if.sv
// rtl/crypto_test_mem_bist_master_if.sv - Avalon-MM bus between the BIST master and the target RAM slave
//
// Purpose : bundles the single-port RAM slave signals (no waitrequest, fixed read latency).
// Signals : avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken
//           driven by the master; avm_readdata driven by the slave.
// Modports: master (BIST engine side), slave (memory side).

interface crypto_test_mem_bist_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_readdata;

    modport master (
        output avm_address,
        output avm_byteenable,
        output avm_chipselect,
        output avm_write,
        output avm_writedata,
        output avm_clken,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_byteenable,
        input  avm_chipselect,
        input  avm_write,
        input  avm_writedata,
        input  avm_clken,
        output avm_readdata
    );
endinterface

// File: rtl/crypto_test_mem_bist_master.sv
// rtl/crypto_test_mem_bist_master.sv - memory BIST master: pattern fill, read back, compare
//
// Purpose : fills a window of the RAM with an address-based or LFSR pattern, reads it back
//           and counts mismatches, recording the first failing address and data.
// Ports   : clk, reset_n (async active-low)
//           start, abort, base_addr, word_count, mode, seed, read_only - test request
//           avm (master modport) - RAM slave bus, READ_LATENCY cycles of read latency
//           busy, done, aborted, err_count, first_err_addr, first_err_data - status/results

module crypto_test_mem_bist_master #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                mode,
    input  logic [DATA_W-1:0]   seed,
    input  logic                read_only,
    crypto_test_mem_bist_master_if.master avm,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data
);

    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h8020_0003);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // FSM strobes consumed by the datapath
    logic accept;       // start taken in IDLE: latch request, clear results
    logic pass_reset;   // write pass finished: rewind the generator for the read pass
    logic set_aborted;
    logic pipe_pending; // valid entries that have not yet reached the compare stage

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   count_clamped;
    logic              mode_q;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] pattern;
    logic              issuing;
    logic              last_word;

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [DATA_W-1:0]       exp_pipe [READ_LATENCY];
    logic [ADDR_W-1:0]       adr_pipe [READ_LATENCY];
    logic                    mismatch;

    // An all-zero seed would lock the LFSR, so it is forced to 1.
    function automatic logic [DATA_W-1:0] seed_fix(input logic [DATA_W-1:0] s);
        seed_fix = (s == '0) ? DATA_ONE : s;
    endfunction

    // Right-shifting Galois LFSR: the bit shifted out selects the tap mask.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
        lfsr_next = x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
    endfunction

    assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign issuing       = (state_q == S_WRITE) || (state_q == S_READ);
    assign last_word     = (idx_q == (cnt_q - IDX_ONE));
    assign pattern       = mode_q ? lfsr_q
                                  : (seed_q ^ {{(DATA_W-ADDR_W){1'b0}}, addr_q});

    // Only the stages ahead of the compare stage matter: the last stage is
    // compared on the same edge that leaves DRAIN.
    always_comb begin
        pipe_pending = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pipe_pending = pipe_pending | vld_pipe[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        pass_reset  = 1'b0;
        set_aborted = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (count_clamped == '0) begin
                        state_d = S_DONE;
                    end else if (read_only) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (abort) begin
                    set_aborted = 1'b1;
                    state_d     = S_DRAIN;
                end else if (last_word) begin
                    pass_reset = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    set_aborted = 1'b1;
                    state_d     = S_DRAIN;
                end else if (last_word) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pipe_pending) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request latch and pattern generator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            mode_q <= 1'b0;
            seed_q <= '0;
            lfsr_q <= '0;
        end else if (accept) begin
            base_q <= base_addr;
            addr_q <= base_addr;
            cnt_q  <= count_clamped;
            idx_q  <= '0;
            mode_q <= mode;
            seed_q <= seed;
            lfsr_q <= seed_fix(seed);
        end else if (pass_reset) begin
            addr_q <= base_q;
            idx_q  <= '0;
            lfsr_q <= seed_fix(seed_q);
        end else if (issuing) begin
            addr_q <= addr_q + ADDR_ONE;   // wraps silently at the top of memory
            idx_q  <= idx_q + IDX_ONE;
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // Expected-data pipeline matching the RAM read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                exp_pipe[i] <= '0;
                adr_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= (state_q == S_READ);
            exp_pipe[0] <= pattern;
            adr_pipe[0] <= addr_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
                adr_pipe[i] <= adr_pipe[i-1];
            end
        end
    end

    assign mismatch = vld_pipe[READ_LATENCY-1]
                      && (avm.avm_readdata != exp_pipe[READ_LATENCY-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            aborted        <= 1'b0;
        end else if (accept) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            aborted        <= 1'b0;
        end else begin
            if (set_aborted) begin
                aborted <= 1'b1;
            end
            if (mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == '0) begin
                    first_err_addr <= adr_pipe[READ_LATENCY-1];
                    first_err_data <= avm.avm_readdata;
                end
            end
        end
    end

    assign busy = issuing || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    assign avm.avm_address    = issuing ? addr_q : '0;
    assign avm.avm_chipselect = issuing;
    assign avm.avm_write      = (state_q == S_WRITE);
    assign avm.avm_writedata  = (state_q == S_WRITE) ? pattern : '0;
    assign avm.avm_byteenable = issuing ? '1 : '0;
    assign avm.avm_clken      = 1'b1;

endmodule

// File: tb/tb_crypto_test_mem_bist_master.sv
// tb/tb_crypto_test_mem_bist_master.sv - self-checking bench for crypto_test_mem_bist_master

module tb_crypto_test_mem_bist_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          mode;
    logic [DW-1:0] seed;
    logic          read_only;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    crypto_test_mem_bist_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    crypto_test_mem_bist_master #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .mode           (mode),
        .seed           (seed),
        .read_only      (read_only),
        .avm            (bus),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    // RAM model: 4096 x 32, no waitrequest, one cycle of read latency
    logic [31:0] mem [4096];
    logic [31:0] rdata = '0;
    logic        fill_req = 1'b0;
    logic        fill_zero = 1'b0;
    logic        corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = '0;
    logic [31:0] corrupt_mask = '0;
    logic [11:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [11:0] rd_addr_q [$];
    int          viol = 0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int a = 0; a < 4096; a++) mem[a] <= fill_zero ? 32'h0 : $urandom;
        end else if (bus.avm_chipselect) begin
            if (bus.avm_write) begin
                mem[bus.avm_address] <= bus.avm_writedata;
                wr_addr_q.push_back(bus.avm_address);
                wr_data_q.push_back(bus.avm_writedata);
            end else begin
                rdata <= mem[bus.avm_address]
                         ^ ((corrupt_en && bus.avm_address == corrupt_addr) ? corrupt_mask : 32'h0);
                rd_addr_q.push_back(bus.avm_address);
            end
        end
    end
    assign bus.avm_readdata = rdata;

    // Bus-rule monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.avm_write && !bus.avm_chipselect) viol++;
            if (bus.avm_byteenable != (bus.avm_chipselect ? 4'hF : 4'h0)) viol++;
            if (bus.avm_chipselect && !busy) viol++;
            if (bus.avm_clken !== 1'b1) viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    task automatic fill_mem(input logic zero);
        @(negedge clk);
        fill_zero = zero;
        fill_req  = 1'b1;
        @(posedge clk);
        #1 fill_req = 1'b0;
    endtask

    // One complete test: reference model, stimulus, then result checks.
    // abort_at / mid_start_at are cycle numbers after the start edge (0 = unused).
    task automatic run_test(input string name, input logic [11:0] base, input logic [12:0] cnt_in,
                            input logic md, input logic [31:0] sd, input logic ro,
                            input int abort_at, input int mid_start_at);
        int          n, nw, nr, ntot, lat_exp, lat, e_err, wb, rb, vb, bad;
        logic [31:0] pat [$];
        logic [11:0] adr [$];
        logic [31:0] m [4096];
        logic [31:0] p, rd;
        logic [11:0] e_faddr;
        logic [31:0] e_fdata;
        logic        e_ab, got_done;

        n = (cnt_in > 13'd4096) ? 4096 : int'(cnt_in);
        p = '0;
        for (int i = 0; i < n; i++) begin
            adr.push_back(12'((int'(base) + i) % 4096));
            if (md) p = (i == 0) ? ((sd == 0) ? 32'h1 : sd) : lfsr_step(p);
            else    p = sd ^ {20'h0, adr[i]};
            pat.push_back(p);
        end
        ntot = (ro ? 0 : n) + n;
        if (n == 0) begin
            nw = 0; nr = 0; e_ab = 1'b0; lat_exp = 1;
        end else if (abort_at > 0 && abort_at <= ntot) begin
            e_ab = 1'b1; lat_exp = abort_at + 2;
            if (!ro && abort_at <= n) begin nw = abort_at; nr = 0; end
            else begin nw = ro ? 0 : n; nr = abort_at - nw; end
        end else begin
            e_ab = 1'b0; nw = ro ? 0 : n; nr = n; lat_exp = ntot + RL + 1;
        end
        m = mem;
        for (int i = 0; i < nw; i++) m[adr[i]] = pat[i];
        e_err = 0; e_faddr = '0; e_fdata = '0;
        for (int i = 0; i < nr; i++) begin
            rd = m[adr[i]] ^ ((corrupt_en && adr[i] == corrupt_addr) ? corrupt_mask : 32'h0);
            if (rd != pat[i]) begin
                if (e_err == 0) begin e_faddr = adr[i]; e_fdata = rd; end
                e_err++;
            end
        end

        wb = wr_addr_q.size(); rb = rd_addr_q.size(); vb = viol;
        @(negedge clk);
        base_addr = base; word_count = cnt_in; mode = md; seed = sd; read_only = ro;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; got_done = 1'b0;
        while (lat < 10000 && !got_done) begin
            @(negedge clk);
            lat++;
            if (lat == abort_at) abort = 1'b1;
            start = (lat == mid_start_at);
            if (lat == 1) check({name, ".busy_t1"}, busy, (n > 0));
            if (done) got_done = 1'b1;
        end
        abort = 1'b0; start = 1'b0;
        check({name, ".done_cycle"}, got_done ? lat : -1, lat_exp);
        check({name, ".err_count"}, err_count, e_err);
        check({name, ".first_err_addr"}, first_err_addr, e_faddr);
        check({name, ".first_err_data"}, first_err_data, e_fdata);
        check({name, ".aborted"}, aborted, e_ab);
        check({name, ".n_writes"}, wr_addr_q.size() - wb, nw);
        check({name, ".n_reads"}, rd_addr_q.size() - rb, nr);
        bad = 0;
        for (int i = 0; i < nw && wb + i < wr_addr_q.size(); i++)
            if (wr_addr_q[wb+i] != adr[i] || wr_data_q[wb+i] != pat[i]) bad++;
        check({name, ".write_content"}, bad, 0);
        bad = 0;
        for (int i = 0; i < nr && rb + i < rd_addr_q.size(); i++)
            if (rd_addr_q[rb+i] != adr[i]) bad++;
        check({name, ".read_addrs"}, bad, 0);
        @(negedge clk);
        check({name, ".idle_after"}, {busy, done}, 2'b00);
        check({name, ".bus_rules"}, viol - vb, 0);
    endtask

    initial begin
        int n, ntot, ab, ms;
        logic [11:0] b;
        logic [12:0] c;
        logic        md, ro;
        logic [31:0] sd;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
        mode = 1'b0; seed = '0; read_only = 1'b0;
        #23;
        check("reset.status", {busy, done, aborted}, 3'b000);
        check("reset.err", {err_count, first_err_addr, first_err_data}, 0);
        check("reset.bus", {bus.avm_chipselect, bus.avm_write, bus.avm_byteenable,
                            bus.avm_address}, 0);
        check("reset.wdata", bus.avm_writedata, 0);
        check("reset.clken", bus.avm_clken, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        // abort alone in IDLE does nothing
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_abort", {busy, done, aborted}, 3'b000);
        abort = 1'b0;

        fill_mem(1'b0);
        run_test("t1", 12'h000, 13'd16, 1'b0, 32'hA5A5_0000, 1'b0, 0, 0);
        run_test("t2", 12'hFFE, 13'd4, 1'b1, 32'h0, 1'b0, 0, 0);
        corrupt_en = 1'b1; corrupt_addr = 12'h000; corrupt_mask = 32'h1;
        run_test("t3", 12'hFFE, 13'd4, 1'b1, 32'h0, 1'b0, 0, 0);
        corrupt_en = 1'b0;
        run_test("t4", 12'h123, 13'd0, 1'b0, 32'h1234_5678, 1'b0, 0, 0);
        run_test("t5", 12'h000, 13'd4096, 1'b0, 32'hDEAD_BEEF, 1'b0, 9, 0);
        fill_mem(1'b1);
        run_test("t6", 12'h000, 13'd8, 1'b0, 32'h0, 1'b1, 0, 4);
        run_test("clamp", 12'h800, 13'd5000, 1'b1, 32'h0BAD_F00D, 1'b1, 0, 0);

        for (int t = 0; t < 12; t++) begin
            fill_mem($urandom_range(0, 1) == 1);
            b  = 12'($urandom);
            c  = 13'($urandom_range(0, 40));
            md = 1'($urandom);
            ro = ($urandom_range(0, 3) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            n  = int'(c);
            ntot = (ro ? 0 : n) + n;
            ab = (ntot > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, ntot) : 0;
            ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
            corrupt_en   = (n > 0 && $urandom_range(0, 1) == 1);
            corrupt_addr = 12'((int'(b) + ((n > 0) ? $urandom_range(0, n - 1) : 0)) % 4096);
            corrupt_mask = 32'h1 << $urandom_range(0, 31);
            run_test($sformatf("rnd%0d", t), b, c, md, sd, ro, ab, ms);
        end
        corrupt_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
